inta_sequencer: RTL

Interrupt-acknowledge sequencer for the 8259A PIC: the initiator side of the in-service-register handshake. It raises INT toward the CPU, tracks the two-pulse INTA cycle, commands the ISR to latch the winning IR line (readPriority), commands the vector byte (sendVector), and signals end of INTA2 (secondACK) for AEOI. It sits between the CPU bus pins, the priority resolver and the in-service register.

---
 rtl/pic_pkg.sv | 20 ++
 rtl/pic_edge_detect.sv | 28 ++
 rtl/inta_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A interrupt-acknowledge path.
package pic_pkg;

  // Sequencer states for the two-pulse INTA handshake
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK1,
    WAIT2,
    VEC,
    DRIVE
  } seq_state_e;

  // IR line reported when INTA1 arrives with no pending request
  localparam logic [2:0] SPURIOUS_IR = 3'd7;

  // Default ack wait budget in cycles, used only when the timeout is built
  localparam int unsigned DEFAULT_ACK_TIMEOUT = 16;

endpackage

// File: rtl/pic_edge_detect.sv
// Registers a level and reports rise, fall and toggle against last cycle's value.
module pic_edge_detect #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_toggle
);

  logic r_prev;

  // Keep last cycle's level for edge comparison
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= ResetVal;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise   = ~r_prev & i_level;
  assign o_fall   = r_prev & ~i_level;
  assign o_toggle = r_prev ^ i_level;

endmodule

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: raises INT, tracks INTA1/INTA2, commands the
// ISR latch and vector drive, and pulses secondACK at the end of INTA2.
// Optional ack timeout is built when INTA_ACK_TIMEOUT_EN is defined.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inta_n,
  input  logic       irrPending,
  input  logic [2:0] highestIndex,
  input  logic       readPriorityAck,
  input  logic       sendVectorAck,
  output logic       INT,
  output logic [2:0] toSet,
  output logic       readPriority,
  output logic       sendVector,
  output logic       secondACK,
  output logic       dataEnable,
  output logic       seqError
);

  logic w_inta_fall;
  logic w_inta_rise;
  logic w_rpa_toggle;
  logic w_sva_toggle;
  logic w_timeout;

  seq_state_e r_state, w_state_next;
  logic       r_int, w_int_next;
  logic [2:0] r_to_set, w_to_set_next;
  logic       r_read_pri, w_read_pri_next;
  logic       r_send_vec, w_send_vec_next;
  logic       r_second_ack, w_second_ack_next;
  logic       r_data_en, w_data_en_next;

  // inta_n idles high, so start its history high to avoid a false fall
  pic_edge_detect #(
    .ResetVal (1'b1)
  ) u_inta_edge (
    .clk      (clk),
    .reset    (reset),
    .i_level  (inta_n),
    .o_rise   (w_inta_rise),
    .o_fall   (w_inta_fall),
    .o_toggle ()
  );

  pic_edge_detect #(
    .ResetVal (1'b0)
  ) u_rpa_edge (
    .clk      (clk),
    .reset    (reset),
    .i_level  (readPriorityAck),
    .o_rise   (),
    .o_fall   (),
    .o_toggle (w_rpa_toggle)
  );

  pic_edge_detect #(
    .ResetVal (1'b0)
  ) u_sva_edge (
    .clk      (clk),
    .reset    (reset),
    .i_level  (sendVectorAck),
    .o_rise   (),
    .o_fall   (),
    .o_toggle (w_sva_toggle)
  );

`ifdef INTA_ACK_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

  logic [CntW-1:0] r_cnt;
  logic            r_seq_err;
  logic            w_wait_ack;
  logic            w_ack_toggle;

  assign w_wait_ack   = (r_state == ACK1) || (r_state == VEC);
  assign w_ack_toggle = (r_state == ACK1) ? w_rpa_toggle : w_sva_toggle;
  // Fires in the last permitted waiting cycle if the ack still has not toggled
  assign w_timeout    = w_wait_ack && !w_ack_toggle && (r_cnt == CntW'(ACK_TIMEOUT - 1));

  // Wait counter restarts on every state change and runs while waiting for an ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_seq_err <= 1'b0;
    end else begin
      r_seq_err <= w_timeout;
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (w_wait_ack) begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign seqError = r_seq_err;
`else
  assign w_timeout = 1'b0;
  assign seqError  = 1'b0;
`endif

  // Next-state and registered-output decode
  always_comb begin
    w_state_next      = r_state;
    w_int_next        = 1'b0;
    w_to_set_next     = r_to_set;
    w_read_pri_next   = 1'b0;
    w_send_vec_next   = 1'b0;
    w_second_ack_next = 1'b0;
    w_data_en_next    = r_data_en;
    unique case (r_state)
      IDLE: begin
        if (w_inta_fall) begin
          // INTA1 straight from IDLE latches the spurious index when nothing is pending
          w_to_set_next   = irrPending ? highestIndex : SPURIOUS_IR;
          w_read_pri_next = 1'b1;
          w_state_next    = ACK1;
        end else if (irrPending) begin
          w_int_next   = 1'b1;
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (w_inta_fall) begin
          w_to_set_next   = irrPending ? highestIndex : SPURIOUS_IR;
          w_read_pri_next = 1'b1;
          w_state_next    = ACK1;
        end else if (!irrPending) begin
          w_state_next = IDLE;
        end else begin
          w_int_next = 1'b1;
        end
      end
      ACK1: begin
        if (w_rpa_toggle) begin
          // A fall coincident with the ack is taken as INTA2
          if (w_inta_fall) begin
            w_send_vec_next = 1'b1;
            w_state_next    = VEC;
          end else begin
            w_state_next = WAIT2;
          end
        end else if (w_timeout) begin
          w_state_next = IDLE;
        end
      end
      WAIT2: begin
        if (w_inta_fall) begin
          w_send_vec_next = 1'b1;
          w_state_next    = VEC;
        end
      end
      VEC: begin
        if (w_sva_toggle) begin
          w_data_en_next = 1'b1;
          w_state_next   = DRIVE;
        end else if (w_timeout) begin
          w_data_en_next = 1'b0;
          w_state_next   = IDLE;
        end
      end
      DRIVE: begin
        if (w_inta_rise) begin
          w_data_en_next    = 1'b0;
          w_second_ack_next = 1'b1;
          w_state_next      = IDLE;
        end
      end
      default: begin
        w_data_en_next = 1'b0;
        w_state_next   = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any sequence in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_int        <= 1'b0;
      r_to_set     <= 3'd0;
      r_read_pri   <= 1'b0;
      r_send_vec   <= 1'b0;
      r_second_ack <= 1'b0;
      r_data_en    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_int        <= w_int_next;
      r_to_set     <= w_to_set_next;
      r_read_pri   <= w_read_pri_next;
      r_send_vec   <= w_send_vec_next;
      r_second_ack <= w_second_ack_next;
      r_data_en    <= w_data_en_next;
    end
  end

  assign INT          = r_int;
  assign toSet        = r_to_set;
  assign readPriority = r_read_pri;
  assign sendVector   = r_send_vec;
  assign secondACK    = r_second_ack;
  assign dataEnable   = r_data_en;

endmodule
